// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the set-associative cache.
//   cache_state_t : miss-handling FSM states
//   age_width()   : bits needed for a per-way LRU age (and a way index)
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        RESPOND
    } cache_state_t;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned age_width(input int unsigned ways);
        return (ways < 2) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/lru_update.sv
// lru_update: next-age vector for the ways of one set after an access.
//   age_i     : current ages of every way in the set (a permutation of 0..WAYS-1)
//   touched_i : way that completed an access
//   age_o     : touched way becomes WAYS-1; ways older-ranked than it shift down by one
module lru_update
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned AGE_W = age_width(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] age_i,
    input  logic [AGE_W-1:0]           touched_i,
    output logic [WAYS-1:0][AGE_W-1:0] age_o
);

    always_comb begin
        age_o = age_i;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (AGE_W'(w) == touched_i) begin
                age_o[w] = AGE_W'(WAYS - 1);
            end else if (age_i[w] > age_i[touched_i]) begin
                age_o[w] = age_i[w] - AGE_W'(1);
            end
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: write-back, write-allocate set-associative cache, one word per line.
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   req_i, write_enable_i,
//   byte_op_i, address_i,
//   write_data_i                  : CPU access (held stable while stall_o=1)
//   read_data_o, stall_o          : load result (byte loads zero-extended), busy
//   mem_req_o, mem_we_o,
//   mem_address_o,
//   mem_write_data_o              : backing-memory request (registered)
//   mem_ready_i, mem_read_data_i  : backing-memory handshake and refill word
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SET_BITS = 4,
    parameter int unsigned WAYS     = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic             byte_op_i,
    input  logic [WIDTH-1:0] address_i,
    input  logic [WIDTH-1:0] write_data_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [WIDTH-1:0] mem_address_o,
    output logic [WIDTH-1:0] mem_write_data_o,
    input  logic             mem_ready_i,
    input  logic [WIDTH-1:0] mem_read_data_i
);

    localparam int unsigned SETS  = 1 << SET_BITS;
    localparam int unsigned AGE_W = age_width(WAYS);
    localparam int unsigned TAG_W = WIDTH - SET_BITS - 2;

    typedef logic [AGE_W-1:0] way_t;

    // Line storage
    logic [WIDTH-1:0]            data_q  [SETS][WAYS];
    logic [TAG_W-1:0]            tag_q   [SETS][WAYS];
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0]             dirty_q [SETS];
    logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];

    cache_state_t state_q;
    way_t         victim_q;

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [4:0]          lane_shift;

    assign set_idx    = address_i[SET_BITS+1:2];
    assign req_tag    = address_i[WIDTH-1:SET_BITS+2];
    assign lane_shift = {address_i[1:0], 3'b000};

    // Hit detection and victim selection for the addressed set
    logic                       hit;
    way_t                       hit_way;
    way_t                       victim_way;
    logic                       found_inv;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = req_i;
                hit_way = way_t'(w);
            end
        end
    end

    // Scan downward so the lowest-index invalid way wins.
    always_comb begin
        found_inv  = 1'b0;
        victim_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!found_inv && age_q[set_idx][w] == '0) begin
                victim_way = way_t'(w);
            end
        end
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!valid_q[set_idx][WAYS-1-i]) begin
                found_inv  = 1'b1;
                victim_way = way_t'(WAYS - 1 - i);
            end
        end
    end

    // Access completion: a hit in IDLE or the replayed access in RESPOND
    logic             access_done;
    way_t             touched;
    logic [WIDTH-1:0] line_word;
    logic [WIDTH-1:0] byte_mask;
    logic [WIDTH-1:0] merged_word;
    logic [WIDTH-1:0] shifted_word;

    assign access_done = req_i && ((state_q == IDLE && hit) || state_q == RESPOND);
    assign touched     = (state_q == RESPOND) ? victim_q : hit_way;
    assign line_word   = data_q[set_idx][touched];
    assign byte_mask   = WIDTH'({BYTE_W{1'b1}}) << lane_shift;
    assign shifted_word = line_word >> lane_shift;

    always_comb begin
        if (byte_op_i) begin
            merged_word = (line_word & ~byte_mask) |
                          (WIDTH'(write_data_i[BYTE_W-1:0]) << lane_shift);
        end else begin
            merged_word = write_data_i;
        end
    end

    always_comb begin
        read_data_o = '0;
        if (access_done) begin
            read_data_o = byte_op_i ? WIDTH'(shifted_word[BYTE_W-1:0]) : line_word;
        end
    end

    assign stall_o = req_i && ((state_q == IDLE && !hit) ||
                               state_q == WRITEBACK || state_q == REFILL);

    logic [WAYS-1:0][AGE_W-1:0] age_next;

    lru_update #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .age_i     (age_q[set_idx]),
        .touched_i (touched),
        .age_o     (age_next)
    );

    logic refill_done;
    assign refill_done = (state_q == REFILL) && mem_ready_i;

    // Miss FSM with registered memory-side outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            victim_q         <= '0;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_address_o    <= '0;
            mem_write_data_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && !hit) begin
                        victim_q  <= victim_way;
                        mem_req_o <= 1'b1;
                        if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
                            state_q          <= WRITEBACK;
                            mem_we_o         <= 1'b1;
                            mem_address_o    <= {tag_q[set_idx][victim_way], set_idx, 2'b00};
                            mem_write_data_o <= data_q[set_idx][victim_way];
                        end else begin
                            state_q       <= REFILL;
                            mem_we_o      <= 1'b0;
                            mem_address_o <= {address_i[WIDTH-1:2], 2'b00};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready_i) begin
                        state_q       <= REFILL;
                        mem_we_o      <= 1'b0;
                        mem_address_o <= {address_i[WIDTH-1:2], 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ready_i) begin
                        state_q   <= RESPOND;
                        mem_req_o <= 1'b0;
                    end
                end
                RESPOND: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_o <= 1'b0;
                    mem_we_o  <= 1'b0;
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            data_q[set_idx][victim_q] <= mem_read_data_i;
            tag_q[set_idx][victim_q]  <= req_tag;
        end else if (access_done && write_enable_i) begin
            data_q[set_idx][touched] <= merged_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            if (refill_done) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= 1'b0;
            end
            if (access_done) begin
                age_q[set_idx] <= age_next;
                if (write_enable_i) begin
                    dirty_q[set_idx][touched] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter WIDTH, default 32: data/address width in bits.
REQ-002 Parameter SET_BITS, default 4: log2 of set count; set index = address_i[SET_BITS+1:2].
REQ-003 Parameter WAYS, default 4: associativity; power of two, 2..8.
REQ-004 Port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst_ni  input  1  asynchronous, active-low reset.
REQ-006 Port req_i  input  1  CPU access valid.
REQ-007 Port write_enable_i  input  1  1 = store, 0 = load.
REQ-008 Port byte_op_i  input  1  byte access; lane = address_i[1:0].
REQ-009 Port address_i  input  WIDTH  byte address; tag = address_i[WIDTH-1:SET_BITS+2].
REQ-010 Port write_data_i  input  WIDTH  store data; byte store uses [7:0].
REQ-011 Port read_data_o  output  WIDTH  load data; byte load zero-extended.
REQ-012 Port stall_o  output  1  access not yet complete; CPU holds all inputs stable.
REQ-013 Port mem_req_o / mem_we_o  output  1 each  memory request / write strobe.
REQ-014 Port mem_address_o / mem_write_data_o  output  WIDTH each  word-aligned address, write-back data.
REQ-015 Port mem_ready_i  input  1  memory accepted write or returned read this cycle.
REQ-016 Port mem_read_data_i  input  WIDTH  refill word, valid when mem_ready_i=1.

Function
REQ-017 Line = one WIDTH-bit word; per way per set: data, tag, valid, dirty, age (log2(WAYS) bits).
REQ-018 Hit = req_i and valid and tag match in exactly one way; hit resolved combinationally same cycle, stall_o=0, read_data_o valid same cycle.
REQ-019 Store hit: byte or word merged at next edge; dirty set; no memory traffic (write-back, write-allocate).
REQ-020 Miss: stall_o=1 combinationally same cycle; FSM leaves IDLE at next edge.
REQ-021 FSM states IDLE, WRITEBACK, REFILL, RESPOND; IDLE->WRITEBACK if victim valid and dirty, else IDLE->REFILL; WRITEBACK->REFILL on mem_ready_i; REFILL->RESPOND on mem_ready_i; RESPOND->IDLE unconditionally.
REQ-022 WRITEBACK: mem_req_o=1, mem_we_o=1, address={victim tag, set, 2'b00}, data=victim word, held until mem_ready_i.
REQ-023 REFILL: mem_req_o=1, mem_we_o=0, address={address_i[WIDTH-1:2], 2'b00}; on mem_ready_i victim written with refill word, tag, valid=1, dirty=0.
REQ-024 RESPOND: stall_o=0; access completes as hit (load returns data, store merges and sets dirty).
REQ-025 Victim: lowest-index invalid way; else way with age 0; chosen in IDLE, registered until RESPOND.
REQ-026 LRU: on every completed access, touched way age := WAYS-1; every other way with age > touched way's old age decrements by 1; ages in a set remain a permutation of 0..WAYS-1.
REQ-027 req_i=0: read_data_o=0, stall_o=0, no state change; mem_req_o=0 in IDLE.
REQ-028 mem_ready_i ignored in IDLE and RESPOND.
REQ-029 Miss minimum latency: clean 3 cycles, dirty 4 cycles (memory ready first cycle).

Reset
REQ-030 rst_ni low asynchronously: FSM IDLE, all valid/dirty 0, age of way w = w in every set, mem_req_o=0, mem_we_o=0, stall_o=0.
REQ-031 Reset mid-WRITEBACK/REFILL abandons the transaction; no partial line install; data arrays need no reset.

Structure
REQ-032 Package cache_pkg holds state enum cache_state_t and age-width function clog2-based constant.
REQ-033 One sub-module lru_update: combinational next-age vector for one set given touched way.

Verification
REQ-034 Reset, load 0x0000_0040 with mem returning 0xDEADBEEF after 2 cycles -> stall 4 cycles, read_data_o=0xDEADBEEF, repeat load hits with stall_o=0.
REQ-035 Byte load address 0x0000_0043 after word 0xDEADBEEF cached -> read_data_o=0x0000_00DE, no mem_req_o.
REQ-036 Fill all 4 ways of set 0 (tags 1..4), touch tag 1, miss tag 5 -> tag 2 evicted, tag 1 still hits.
REQ-037 Store 0x12345678 to cached line, force eviction -> WRITEBACK with mem_we_o=1, mem_write_data_o=0x12345678, then REFILL.
REQ-038 Assert rst_ni during REFILL -> mem_req_o=0 immediately, subsequent load to same address misses.
REQ-039 Re-run REQ-036 with WAYS=8, SET_BITS=2 -> LRU ordering and tag slicing correct.
